g709_enc_sched: RTL and testbench

Frame-level scheduler that shares one `g709_enc` (16-byte interleaved RS(255,239), 128-bit words, 255 words per frame) between NCH payload requesters.
- Accepts 239-word payload frames from each requester over a valid/ready handshake.
- Arbitrates at frame granularity and drives the encoder input with 239 data words followed by 16 zero parity-slot words.
- Tracks which channel owns each frame at the encoder output through a tag FIFO, so downstream demux (QPSK mapper / line side) can route the coded frame.

---
 rtl/g709_enc_sched.sv | 184 ++++++++++++++++++
 tb/tb_g709_enc_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g709_enc_sched.sv
// g709_enc_sched: frame-level scheduler sharing one g709_enc between NCH requesters.
// Each granted frame is 239 payload words followed by 16 zero parity-slot words.
// A tag FIFO records the owning channel so the coded frame can be routed downstream.
// Build option: define G709_ENC_SCHED_STRICT_PRIO_EN for fixed priority (lowest channel wins).
module g709_enc_sched #(
    parameter int NCH       = 2,
    parameter int CW        = 1,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic [NCH-1:0]       ireq_val,
    input  logic [NCH-1:0]       ireq_sop,
    input  logic [NCH*128-1:0]   ireq_dat,
    output logic [NCH-1:0]       oreq_rdy,
    output logic                 oenc_val,
    output logic                 oenc_sop,
    output logic [127:0]         oenc_dat,
    input  logic                 ienc_oval,
    input  logic                 ienc_osop,
    output logic                 ochan_val,
    output logic [CW-1:0]        ochan,
    output logic                 odrop,
    output logic                 oerr
);
    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   gnt;
    logic [7:0]      wcnt;
    logic [3:0]      pcnt;
    logic [7:0]      ocnt;
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [CW-1:0]   tag_mem [TAG_DEPTH];

    logic [127:0]    req_word [NCH];
    logic [NCH-1:0]  cand;
    logic            arb_hit;
    logic [CW-1:0]   arb_idx;
    logic [CW-1:0]   arb_sel;
    logic            fifo_empty;
    logic            fifo_full;
    logic            grant;
    logic            acc;
    logic            pop;

    for (genvar c = 0; c < NCH; c++) begin : g_word
        assign req_word[c] = ireq_dat[c*128 +: 128];
    end

    assign cand       = ireq_val & ireq_sop;
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign grant      = iclkena && (state == IDLE) && arb_hit && !fifo_full;
    assign acc        = iclkena && (state == DATA) && ireq_val[gnt];
    assign pop        = iclkena && ienc_oval && !ienc_osop && (ocnt == 8'd254) && !fifo_empty;
    assign ochan_val  = !fifo_empty;
    assign ochan      = fifo_empty ? '0 : tag_mem[rptr[AW-1:0]];

    // Pick the sop candidate closest to the priority start; scanning downward lets the nearest win.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        arb_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
`ifdef G709_ENC_SCHED_STRICT_PRIO_EN
            arb_sel = CW'(i);
`else
            arb_sel = CW'((int'(ptr) + i) % NCH);
`endif
            if (cand[arb_sel]) begin
                arb_hit = 1'b1;
                arb_idx = arb_sel;
            end
        end
    end

    // Next-state and per-channel ready: discards in IDLE, only the owner in DATA, nobody in PAD.
    always_comb begin
        state_nxt = state;
        oreq_rdy  = '0;
        case (state)
            IDLE: begin
                if (iclkena) oreq_rdy = ireq_val & ~ireq_sop;
                if (grant) begin
                    oreq_rdy[arb_idx] = 1'b1;
                    state_nxt         = DATA;
                end
            end
            DATA: begin
                if (iclkena) oreq_rdy[gnt] = 1'b1;
                if (acc && wcnt == 8'd238) state_nxt = PAD;
            end
            PAD: begin
                if (iclkena && pcnt == 4'd15) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset wins over the clock enable.
    always_ff @(posedge iclk) begin
        if (!ireset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Encoder drive, frame counters, tag pointers and output-side word counter.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            ptr      <= '0;
            gnt      <= '0;
            wcnt     <= '0;
            pcnt     <= '0;
            ocnt     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            oenc_val <= 1'b0;
            oenc_sop <= 1'b0;
            oenc_dat <= '0;
            odrop    <= 1'b0;
            oerr     <= 1'b0;
        end else if (iclkena) begin
            oenc_val <= 1'b0;
            oenc_sop <= 1'b0;
            oenc_dat <= '0;
            oerr     <= 1'b0;
            odrop    <= (state == IDLE) && |(ireq_val & ~ireq_sop);
            case (state)
                IDLE: begin
                    if (grant) begin
                        oenc_val <= 1'b1;
                        oenc_sop <= 1'b1;
                        oenc_dat <= req_word[arb_idx];
                        gnt      <= arb_idx;
                        wcnt     <= 8'd1;
                        wptr     <= wptr + 1'b1;
`ifdef G709_ENC_SCHED_STRICT_PRIO_EN
                        ptr      <= '0;
`else
                        ptr      <= (arb_idx == CW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
`endif
                    end
                end
                DATA: begin
                    if (acc) begin
                        oenc_val <= 1'b1;
                        oenc_dat <= req_word[gnt];
                        wcnt     <= wcnt + 8'd1;
                        if (ireq_sop[gnt]) oerr <= 1'b1;
                        if (wcnt == 8'd238) pcnt <= '0;
                    end
                end
                PAD: begin
                    oenc_val <= 1'b1;
                    pcnt     <= pcnt + 4'd1;
                end
                default: ;
            endcase
            if (pop) rptr <= rptr + 1'b1;
            if (ienc_oval) begin
                if (ienc_osop) begin
                    ocnt <= 8'd1;
                    if (fifo_empty) oerr <= 1'b1;
                end else if (ocnt == 8'd254) begin
                    ocnt <= '0;
                end else begin
                    ocnt <= ocnt + 8'd1;
                end
            end
        end
    end

    // Tag storage; the owning channel is written at grant time.
    always_ff @(posedge iclk) begin
        if (ireset && grant) tag_mem[wptr[AW-1:0]] <= arb_idx;
    end

endmodule

// File: tb/tb_g709_enc_sched.sv
// tb_g709_enc_sched: directed self-checking bench for g709_enc_sched (NCH=2, TAG_DEPTH=4).
// The encoder is emulated by driving ienc_oval/ienc_osop directly.
module tb_g709_enc_sched;
    localparam int NCH       = 2;
    localparam int CW        = 1;
    localparam int TAG_DEPTH = 4;

    logic                iclk = 1'b0;
    logic                ireset;
    logic                iclkena;
    logic [NCH-1:0]      ireq_val;
    logic [NCH-1:0]      ireq_sop;
    logic [NCH*128-1:0]  ireq_dat;
    logic [NCH-1:0]      oreq_rdy;
    logic                oenc_val;
    logic                oenc_sop;
    logic [127:0]        oenc_dat;
    logic                ienc_oval;
    logic                ienc_osop;
    logic                ochan_val;
    logic [CW-1:0]       ochan;
    logic                odrop;
    logic                oerr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drop_cnt = 0;
    int err_cnt = 0;

    logic [127:0] obs_dat [$];
    bit           obs_sop [$];
    int           obs_cyc [$];
    logic [127:0] exp_dat [$];
    bit           exp_sop [$];
    int           gnt_log [$];
    int           exp_gnt [4];

    always #5 iclk = ~iclk;

    g709_enc_sched #(.NCH(NCH), .CW(CW), .TAG_DEPTH(TAG_DEPTH)) dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .iclkena   (iclkena),
        .ireq_val  (ireq_val),
        .ireq_sop  (ireq_sop),
        .ireq_dat  (ireq_dat),
        .oreq_rdy  (oreq_rdy),
        .oenc_val  (oenc_val),
        .oenc_sop  (oenc_sop),
        .oenc_dat  (oenc_dat),
        .ienc_oval (ienc_oval),
        .ienc_osop (ienc_osop),
        .ochan_val (ochan_val),
        .ochan     (ochan),
        .odrop     (odrop),
        .oerr      (oerr)
    );

    // Free-running cycle index used to time-stamp encoder words.
    always @(posedge iclk) cyc <= cyc + 1;

    // Record every encoder word and count odrop/oerr pulses, sampled mid-cycle.
    always @(negedge iclk) begin
        if (oenc_val) begin
            obs_dat.push_back(oenc_dat);
            obs_sop.push_back(oenc_sop);
            obs_cyc.push_back(cyc);
        end
        if (odrop) drop_cnt <= drop_cnt + 1;
        if (oerr)  err_cnt  <= err_cnt + 1;
    end

    function automatic logic [127:0] pat(input int ch, input int f, input int w);
        pat = {4{8'(ch + 1), 8'(f), 16'(w)}};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] val, input logic [1:0] sop,
                                 input logic [127:0] d0, input logic [127:0] d1);
        ireq_val = val;
        ireq_sop = sop;
        ireq_dat = {d1, d0};
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    // Drive frames on both channels; the expected encoder stream is built from accepted words.
    task automatic runTraffic(input int nfr0, input int nfr1, input bit gap1,
                              input int errat0, input int stop_at, input int budget);
        int left [2];
        int widx [2];
        int fnum [2];
        int errat [2];
        logic [1:0] v;
        logic [1:0] s;
        logic [127:0] d [2];
        int n;
        bit done;
        left[0] = nfr0;  left[1] = nfr1;
        widx[0] = 0;     widx[1] = 0;
        fnum[0] = 0;     fnum[1] = 0;
        errat[0] = errat0; errat[1] = -1;
        done = 1'b0;
        n = 0;
        while (!done && n < budget) begin
            for (int c = 0; c < 2; c++) begin
                v[c] = (left[c] > 0) && !(c == 1 && gap1 && (n % 2) == 1);
                s[c] = v[c] && (widx[c] == 0 || widx[c] == errat[c]);
                d[c] = pat(c, fnum[c], widx[c]);
            end
            applyStimulus(v, s, d[0], d[1]);
            @(negedge iclk);
            for (int c = 0; c < 2; c++) begin
                if (ireq_val[c] && oreq_rdy[c]) begin
                    if (widx[c] == 0) gnt_log.push_back(c);
                    exp_dat.push_back(d[c]);
                    exp_sop.push_back(widx[c] == 0);
                    widx[c]++;
                    if (widx[c] == 239) begin
                        for (int k = 0; k < 16; k++) begin
                            exp_dat.push_back('0);
                            exp_sop.push_back(1'b0);
                        end
                        widx[c] = 0;
                        fnum[c]++;
                        left[c]--;
                    end
                end
            end
            @(posedge iclk);
            #1;
            n++;
            done = (left[0] == 0 && left[1] == 0) || (stop_at > 0 && widx[0] == stop_at);
        end
        applyStimulus('0, '0, '0, '0);
        checkOutput("traffic_done", done, 1'b1);
    endtask

    // Compare the recorded encoder words since 'base' against the expected stream.
    task automatic compareStreams(input string tag, input int base);
        int nobs;
        int nbad;
        nobs = obs_dat.size() - base;
        nbad = 0;
        checkOutput({tag, "_len"}, nobs, exp_dat.size());
        for (int i = 0; i < exp_dat.size() && i < nobs; i++) begin
            if (obs_dat[base + i] !== exp_dat[i] || obs_sop[base + i] !== exp_sop[i]) nbad++;
        end
        checkOutput({tag, "_data"}, nbad, 0);
        exp_dat.delete();
        exp_sop.delete();
    endtask

    // Emulate one 255-word coded frame leaving the encoder and check its routing tag.
    task automatic drainFrame(input int want_ch, input string tag);
        for (int i = 0; i < 255; i++) begin
            ienc_oval = 1'b1;
            ienc_osop = (i == 0);
            @(negedge iclk);
            if (i == 0) begin
                checkOutput({tag, "_chval"}, ochan_val, 1'b1);
                checkOutput({tag, "_ch"}, ochan, want_ch);
            end
            if (i == 254) checkOutput({tag, "_chval_last"}, ochan_val, 1'b1);
            @(posedge iclk);
            #1;
        end
        ienc_oval = 1'b0;
        ienc_osop = 1'b0;
    endtask

    initial begin
        int base;
        int d0;
        int e0;
        int hits;
        ireset    = 1'b0;
        iclkena   = 1'b1;
        ienc_oval = 1'b0;
        ienc_osop = 1'b0;
        applyStimulus('0, '0, '0, '0);
`ifdef G709_ENC_SCHED_STRICT_PRIO_EN
        exp_gnt = '{0, 0, 1, 1};
`else
        exp_gnt = '{0, 1, 0, 1};
`endif

        $display("[TB] reset state");
        waitCycles(3);
        @(negedge iclk);
        checkOutput("rst_oenc_val", oenc_val, 1'b0);
        checkOutput("rst_oenc_sop", oenc_sop, 1'b0);
        checkOutput("rst_oenc_dat", oenc_dat, '0);
        checkOutput("rst_odrop", odrop, 1'b0);
        checkOutput("rst_oerr", oerr, 1'b0);
        checkOutput("rst_ochan_val", ochan_val, 1'b0);
        checkOutput("rst_ochan", ochan, '0);
        checkOutput("rst_rdy", oreq_rdy, '0);
        @(posedge iclk);
        #1;
        ireset = 1'b1;
        waitCycles(2);

        $display("[TB] arbitration with both channels requesting");
        base = obs_dat.size();
        gnt_log.delete();
        runTraffic(2, 2, 1'b0, -1, 0, 2400);
        waitCycles(20);
        compareStreams("rr", base);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_gnt%0d", i), (gnt_log.size() > i) ? gnt_log[i] : -1, exp_gnt[i]);
        end
        for (int i = 0; i < 4; i++) drainFrame(exp_gnt[i], $sformatf("rr_drain%0d", i));
        @(negedge iclk);
        checkOutput("rr_chval_empty", ochan_val, 1'b0);
        waitCycles(1);

        $display("[TB] single frame on channel 0");
        base = obs_dat.size();
        runTraffic(1, 0, 1'b0, -1, 0, 600);
        waitCycles(20);
        if (obs_dat.size() - base >= 255) begin
            checkOutput("single_span", obs_cyc[base + 254] - obs_cyc[base], 254);
            checkOutput("single_sop_first", obs_sop[base], 1'b1);
            checkOutput("single_word240", obs_dat[base + 239], '0);
            checkOutput("single_word255", obs_dat[base + 254], '0);
        end
        compareStreams("single", base);
        drainFrame(0, "single_drain");
        @(negedge iclk);
        checkOutput("single_chval_after", ochan_val, 1'b0);
        waitCycles(1);

        $display("[TB] gapped frame on channel 1");
        base = obs_dat.size();
        runTraffic(0, 1, 1'b1, -1, 0, 1200);
        waitCycles(20);
        if (obs_dat.size() - base >= 255) begin
            checkOutput("gap_spread", (obs_cyc[base + 238] - obs_cyc[base]) > 238, 1'b1);
            checkOutput("gap_pad_contig", obs_cyc[base + 254] - obs_cyc[base + 239], 15);
        end
        compareStreams("gap", base);
        drainFrame(1, "gap_drain");

        $display("[TB] protocol errors");
        d0 = drop_cnt;
        applyStimulus(2'b01, 2'b00, pat(0, 7, 7), '0);
        @(negedge iclk);
        checkOutput("drop_rdy", oreq_rdy[0], 1'b1);
        @(posedge iclk);
        #1;
        applyStimulus('0, '0, '0, '0);
        waitCycles(4);
        checkOutput("drop_once", drop_cnt - d0, 1);

        e0 = err_cnt;
        base = obs_dat.size();
        runTraffic(1, 0, 1'b0, 100, 0, 600);
        waitCycles(20);
        compareStreams("sopmid", base);
        checkOutput("sopmid_err", err_cnt - e0, 1);
        drainFrame(0, "sopmid_drain");

        e0 = err_cnt;
        ienc_oval = 1'b1;
        ienc_osop = 1'b1;
        waitCycles(1);
        ienc_oval = 1'b0;
        ienc_osop = 1'b0;
        waitCycles(3);
        checkOutput("osop_empty_err", err_cnt - e0, 1);

        $display("[TB] tag FIFO backpressure");
        e0 = err_cnt;
        base = obs_dat.size();
        gnt_log.delete();
        runTraffic(4, 0, 1'b0, -1, 0, 2400);
        waitCycles(20);
        compareStreams("bp_fill", base);
        hits = 0;
        applyStimulus(2'b01, 2'b01, pat(0, 9, 0), '0);
        repeat (20) begin
            @(negedge iclk);
            if (oreq_rdy[0]) hits++;
            @(posedge iclk);
            #1;
        end
        applyStimulus('0, '0, '0, '0);
        checkOutput("bp_rdy_blocked", hits, 0);
        drainFrame(0, "bp_drain0");
        base = obs_dat.size();
        runTraffic(1, 0, 1'b0, -1, 0, 600);
        waitCycles(20);
        compareStreams("bp_fifth", base);
        for (int i = 0; i < 4; i++) drainFrame(0, $sformatf("bp_drain%0d", i + 1));
        checkOutput("bp_no_err", err_cnt - e0, 0);

        $display("[TB] reset in the middle of a frame");
        runTraffic(1, 0, 1'b0, -1, 50, 600);
        applyStimulus(2'b01, 2'b00, pat(0, 0, 50), '0);
        ireset = 1'b0;
        @(posedge iclk);
        #1;
        @(negedge iclk);
        checkOutput("midrst_oenc_val", oenc_val, 1'b0);
        checkOutput("midrst_chval", ochan_val, 1'b0);
        @(posedge iclk);
        #1;
        ireset = 1'b1;
        applyStimulus('0, '0, '0, '0);
        exp_dat.delete();
        exp_sop.delete();
        waitCycles(2);
        base = obs_dat.size();
        runTraffic(0, 1, 1'b0, -1, 0, 600);
        waitCycles(20);
        compareStreams("post_rst", base);
        drainFrame(1, "post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
